// File: rtl/led_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : led_receiver                                                 |
// | Purpose : 8E1 UART receiver feeding a 4-digit common-anode hex display |
// | Revision: 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module led_receiver #(
    parameter int DIGIT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic       AN0,
    output logic       AN1,
    output logic       AN2,
    output logic       AN3,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp
);

    localparam int c_SCAN_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(DIGIT_CYCLES - 1);
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_F     = 7'b0001110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic        r_rxd_meta, r_rxd_sync;
    logic [13:0] r_div_cnt, w_div_max;
    logic        w_tick, w_start, w_sample;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift, r_byte;
    logic        r_perr, r_ferr, r_err, r_have;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [1:0]  r_digit;
    logic        r_scan_en;
    logic [3:0]  w_nibble, w_an;
    logic [6:0]  w_hex, w_seg;

    always_comb begin
        w_div_max = 14'd26;
        case (baud_select)
            3'b000: w_div_max = 14'd10416;
            3'b001: w_div_max = 14'd2603;
            3'b010: w_div_max = 14'd650;
            3'b011: w_div_max = 14'd325;
            3'b100: w_div_max = 14'd162;
            3'b101: w_div_max = 14'd80;
            3'b110: w_div_max = 14'd53;
            default: w_div_max = 14'd26;
        endcase
    end

    // >= so a mid-count switch to a faster rate cannot overshoot the reload
    assign w_tick   = (r_div_cnt >= w_div_max);
    assign w_start  = (r_state == S_IDLE) && Rx_EN && !r_rxd_sync;
    assign w_sample = w_tick && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_div_cnt  <= '0;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_sync <= r_rxd_meta;
            if (w_start || w_tick)
                r_div_cnt <= '0;
            else
                r_div_cnt <= r_div_cnt + 14'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!Rx_EN) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (!r_rxd_sync) w_next = S_START;
                S_START:  if (w_tick && r_tick_cnt == 4'd7)
                              w_next = r_rxd_sync ? S_IDLE : S_DATA;
                S_DATA:   if (w_sample && r_bit_cnt == 3'd7) w_next = S_PARITY;
                S_PARITY: if (w_sample) w_next = S_STOP;
                S_STOP:   if (w_sample) w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_byte     <= '0;
            r_err      <= 1'b0;
            r_have     <= 1'b0;
        end else begin
            // The half-bit start check realigns the counter to bit centres
            if (r_state == S_IDLE || (r_state == S_START && w_tick && r_tick_cnt == 4'd7))
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= r_tick_cnt + 4'd1;

            if (r_state != S_DATA)
                r_bit_cnt <= '0;
            else if (w_sample)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (r_state == S_DATA && w_sample)
                r_shift <= {r_rxd_sync, r_shift[7:1]};

            if (r_state == S_IDLE) begin
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (r_state == S_PARITY && w_sample)
                r_perr <= (r_rxd_sync != ^r_shift);
            if (r_state == S_STOP && w_sample)
                r_ferr <= !r_rxd_sync;

            if (r_state == S_DONE && Rx_EN) begin
                if (r_perr || r_ferr) begin
                    r_err <= 1'b1;
                end else begin
                    r_err  <= 1'b0;
                    r_have <= 1'b1;
                    r_byte <= r_shift;
                end
            end
        end
    end

    // Scanning starts on the first clock after reset, at the leftmost digit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_en  <= 1'b0;
            r_digit    <= 2'd3;
            r_scan_cnt <= '0;
        end else if (!r_scan_en) begin
            r_scan_en  <= 1'b1;
            r_digit    <= 2'd3;
            r_scan_cnt <= '0;
        end else if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit - 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_nibble = r_digit[0] ? r_byte[7:4] : r_byte[3:0];

    always_comb begin
        w_hex = c_SEG_BLANK;
        case (w_nibble)
            4'h0: w_hex = 7'b1000000;
            4'h1: w_hex = 7'b1111001;
            4'h2: w_hex = 7'b0100100;
            4'h3: w_hex = 7'b0110000;
            4'h4: w_hex = 7'b0011001;
            4'h5: w_hex = 7'b0010010;
            4'h6: w_hex = 7'b0000010;
            4'h7: w_hex = 7'b1111000;
            4'h8: w_hex = 7'b0000000;
            4'h9: w_hex = 7'b0010000;
            4'hA: w_hex = 7'b0001000;
            4'hB: w_hex = 7'b0000011;
            4'hC: w_hex = 7'b1000110;
            4'hD: w_hex = 7'b0100001;
            4'hE: w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase
    end

    always_comb begin
        w_an  = 4'b1111;
        w_seg = c_SEG_BLANK;
        if (r_scan_en) begin
            w_an = ~(4'b0001 << r_digit);
            if (r_err)
                w_seg = c_SEG_F;
            else if (r_have && !r_digit[1])
                w_seg = w_hex;
        end
    end

    assign {AN3, AN2, AN1, AN0}   = w_an;
    assign {g, f, e, d, c, b, a}  = w_seg;
    assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_led_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_led_receiver                                              |
// | Purpose : randomized self-checking bench for led_receiver              |
// | Revision: 1.0 - initial release                                        |
// +-----------------------------------------------------------------------+
module tb_led_receiver;

    localparam int DC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_select = 3'b111;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic       AN0, AN1, AN2, AN3, a, b, c, d, e, f, g, dp;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the display should hold
    logic       exp_err = 1'b0;
    logic       exp_have = 1'b0;
    logic [7:0] exp_byte = 8'h00;

    logic [7:0] rnd_byte;
    logic       rnd_par;
    int         bl, nb;

    always #10 clk = ~clk;

    led_receiver #(.DIGIT_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
        .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        if (exp_err) return 7'b0001110;
        if (!exp_have) return 7'b1111111;
        if (idx == 1) return hex_seg(4'(exp_byte / 16));
        if (idx == 0) return hex_seg(4'(exp_byte % 16));
        return 7'b1111111;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int bitlen);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            RxD = bits[i];
            wait_cyc(bitlen);
        end
        RxD = 1'b1;
        if (par == ^data && stop) begin
            exp_err  = 1'b0;
            exp_have = 1'b1;
            exp_byte = data;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic check_display(input string tag);
        logic [3:0] an, seen;
        int idx;
        seen = 4'h0;
        for (int i = 0; i < 4 * DC; i++) begin
            @(negedge clk);
            an = {AN3, AN2, AN1, AN0};
            chk({tag, "_anode"}, $countones(~an), 1);
            idx = 0;
            for (int k = 0; k < 4; k++) if (!an[k]) idx = k;
            seen[idx] = 1'b1;
            chk({tag, "_seg"}, {g, f, e, d, c, b, a}, exp_seg(idx));
        end
        chk({tag, "_visit"}, seen, 4'hF);
        chk({tag, "_dp"}, dp, 1);
    endtask

    initial begin
        reset = 1'b1;
        wait_cyc(20);
        chk("rst_an", {AN3, AN2, AN1, AN0}, 4'hF);
        chk("rst_seg", {g, f, e, d, c, b, a}, 7'h7F);
        chk("rst_dp", dp, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("first_an", {AN3, AN2, AN1, AN0}, 4'b0111);
        repeat (DC - 1) begin
            @(negedge clk);
            chk("hold_an3", {AN3, AN2, AN1, AN0}, 4'b0111);
        end
        @(negedge clk);
        chk("next_an2", {AN3, AN2, AN1, AN0}, 4'b1011);
        check_display("blank");

        // 115200 baud with bit lengths inside the tolerance window
        send_frame(8'h85, 1'b0, 1'b1, $urandom_range(430, 448));
        check_display("perr85");
        send_frame(8'h23, 1'b1, 1'b1, $urandom_range(430, 448));
        check_display("good23");
        bl = $urandom_range(430, 448);
        send_frame(8'h5A, 1'b0, 1'b0, bl);
        // Low stop bit looks like a fresh start; let that phantom frame run out
        wait_cyc(bl * 10 + 400);
        check_display("ferr5A");

        RxD = 1'b0;
        wait_cyc(5);
        RxD = 1'b1;
        wait_cyc(400);
        check_display("glitch");

        // Abort a frame part way through by dropping the enable
        bl = $urandom_range(430, 448);
        nb = $urandom_range(1, 8);
        rnd_byte = 8'($urandom);
        RxD = 1'b0;
        wait_cyc(bl);
        for (int i = 0; i < nb; i++) begin
            RxD = rnd_byte[i];
            wait_cyc(bl);
        end
        Rx_EN = 1'b0;
        RxD = 1'b1;
        wait_cyc(50);
        Rx_EN = 1'b1;
        wait_cyc(50);
        check_display("abort");

        send_frame(8'h3C, 1'b0, 1'b1, $urandom_range(430, 448));
        check_display("good3C");

        // 9600 baud, random byte with random parity correctness
        baud_select = 3'b011;
        wait_cyc(10);
        rnd_byte = 8'($urandom);
        rnd_par  = 1'($urandom);
        send_frame(rnd_byte, rnd_par, 1'b1, 326 * 16);
        check_display("rand9600");

        // Reset in the middle of a frame blanks the display next edge
        baud_select = 3'b111;
        RxD = 1'b0;
        wait_cyc(1000);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_an", {AN3, AN2, AN1, AN0}, 4'hF);
        chk("midrst_seg", {g, f, e, d, c, b, a}, 7'h7F);
        exp_err  = 1'b0;
        exp_have = 1'b0;
        RxD = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        check_display("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
